// File: rtl/eg_sequential_circuit.sv
// eg_sequential_circuit: two-stage bitwise register pipeline.
//   f <= x1 & x2          (stage 0)
//   g <= f_prev | x3      (stage 1, sees f one cycle late)
// All lanes are independent. Outputs come straight from flops.
module eg_sequential_circuit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g
);

    logic [WIDTH-1:0] f_p0;
    logic [WIDTH-1:0] g_p1;

    // Stage 0: register the AND of the two operands; reset clears it so an
    // in-flight value can never reach stage 1 after a reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_p0 <= '0;
        end else begin
            f_p0 <= x1 & x2;
        end
    end

    // Stage 1: OR the previous stage-0 value with x3.
    always_ff @(posedge clk) begin
        if (rst) begin
            g_p1 <= '0;
        end else begin
            g_p1 <= f_p0 | x3;
        end
    end

    assign f = f_p0;
    assign g = g_p1;

endmodule

// File: tb/tb_eg_sequential_circuit.sv
// Scoreboard bench for eg_sequential_circuit: one WIDTH=1 and one WIDTH=4
// instance share clock and reset. Stimulus pushes the hand-computed outputs
// expected after each rising edge; a monitor pops and compares 1 time unit
// after every rising edge.
module tb_eg_sequential_circuit;

    typedef struct {
        logic [3:0] ef;
        logic [3:0] eg;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] a4, b4, c4;
    logic [3:0] f4, g4;
    logic       a1, b1, c1;
    logic       f1, g1;

    exp_t q[$];
    int   total;
    int   bad;

    eg_sequential_circuit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .x1(a1), .x2(b1), .x3(c1), .f(f1), .g(g1)
    );

    eg_sequential_circuit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .x1(a4), .x2(b4), .x3(c4), .f(f4), .g(g4)
    );

    // Rising edges at 10, 30, 50, ...
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        a4 = a; b4 = b; c4 = c;
        a1 = a[0]; b1 = b[0]; c1 = c[0];
    endtask

    task automatic push(input logic [3:0] ef, input logic [3:0] eg, input string nm);
        exp_t e;
        e.ef = ef; e.eg = eg; e.name = nm;
        q.push_back(e);
    endtask

    // Apply one vector 5 units after a rising edge, for the following edge.
    // A nonzero glitch mask flips x1 at +5 and restores it at +15.
    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] glitch,
                        input logic [3:0] ef, input logic [3:0] eg, input string nm);
        @(posedge clk);
        #5;
        rst = r;
        drive(a ^ glitch, b, c);
        push(ef, eg, nm);
        if (glitch != 4'h0) begin
            #10;
            drive(a, b, c);
        end
    endtask

    // Scalar vector replicated across all four lanes of the wide instance.
    task automatic s1(input logic r, input logic x1v, input logic x2v, input logic x3v,
                      input logic ef, input logic eg, input string nm);
        step(r, {4{x1v}}, {4{x2v}}, {4{x3v}}, 4'h0, {4{ef}}, {4{eg}}, nm);
    endtask

    // Monitor: compare both instances against the oldest expected entry.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                total++;
                if (f4 !== e.ef) begin
                    bad++;
                    $display("FAIL %s f(w4) got=%b want=%b", e.name, f4, e.ef);
                end
                total++;
                if (g4 !== e.eg) begin
                    bad++;
                    $display("FAIL %s g(w4) got=%b want=%b", e.name, g4, e.eg);
                end
                total++;
                if (f1 !== e.ef[0]) begin
                    bad++;
                    $display("FAIL %s f(w1) got=%b want=%b", e.name, f1, e.ef[0]);
                end
                total++;
                if (g1 !== e.eg[0]) begin
                    bad++;
                    $display("FAIL %s g(w1) got=%b want=%b", e.name, g1, e.eg[0]);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(4'h0, 4'h0, 4'h0);
        push(4'h0, 4'h0, "reset_zero");          // edge 10

        s1(1, 1, 1, 1, 0, 0, "reset_inputs_high");
        // nominal sequence
        s1(0, 1, 0, 1, 0, 1, "nom_101");
        s1(0, 1, 1, 0, 1, 0, "nom_110");
        s1(0, 0, 1, 1, 0, 1, "nom_011");
        s1(0, 1, 1, 1, 1, 1, "nom_111");
        s1(0, 0, 0, 0, 0, 1, "nom_000a");
        s1(0, 0, 0, 0, 0, 0, "nom_000b");
        // single-cycle AND pulse travels f then g
        s1(0, 1, 1, 0, 1, 0, "pulse_f");
        s1(0, 0, 0, 0, 0, 1, "pulse_g");
        s1(0, 0, 0, 0, 0, 0, "pulse_clear");
        // x3-only pulse
        s1(0, 0, 0, 1, 0, 1, "x3_pulse");
        s1(0, 0, 0, 0, 0, 0, "x3_clear");
        // mid-run reset discards in-flight f
        s1(0, 1, 1, 0, 1, 0, "mid_set_f");
        s1(1, 1, 1, 0, 0, 0, "mid_reset");
        s1(0, 0, 0, 0, 0, 0, "mid_after");
        // x1 glitch between edges has no effect
        step(0, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, "glitch_f");
        s1(0, 0, 0, 0, 0, 1, "glitch_g");
        // f and x3 coinciding still give g=1
        s1(0, 1, 1, 1, 1, 1, "both_a");
        s1(0, 0, 0, 1, 0, 1, "both_b");
        s1(0, 0, 0, 0, 0, 0, "both_clear");
        // lane independence on the wide instance
        step(0, 4'b1100, 4'b1010, 4'b0001, 4'h0, 4'b1000, 4'b0001, "w4_f");
        step(0, 4'b0000, 4'b0000, 4'b0001, 4'h0, 4'b0000, 4'b1001, "w4_g");
        step(0, 4'b0000, 4'b0000, 4'b0000, 4'h0, 4'b0000, 4'b0000, "w4_clear");

        @(posedge clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
